// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, constants and hazard FSM encoding for the ID/EX stage
package id_ex_stage_pkg;

  localparam int EX_CTRL_W    = 4;
  localparam int MEM_CTRL_W   = 3;
  localparam int WB_CTRL_W    = 2;
  localparam int MEM_READ_IDX = 1;
  localparam int REG_ZERO     = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard detector between ID and EX
module load_use_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      exValid,
  input  logic                      exMemRead,
  input  logic [REG_ADDR_WIDTH-1:0] exRt,
  input  logic                      idValid,
  input  logic [REG_ADDR_WIDTH-1:0] idRs,
  input  logic [REG_ADDR_WIDTH-1:0] idRt,
  output logic                      loadUse
);

  logic rt_nonzero;
  logic rs_match;
  logic rt_match;

  // A load into $0 produces nothing a consumer can depend on.
  assign rt_nonzero = (exRt != REG_ADDR_WIDTH'(REG_ZERO));
  assign rs_match   = (exRt == idRs);
  assign rt_match   = (exRt == idRt);

  assign loadUse = exValid & exMemRead & rt_nonzero & idValid & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and bubble insertion
// Optional hazard counters are built when HAZARD_STATS_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_READ_BIT   = MEM_READ_IDX
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] idRs,
  input  logic [REG_ADDR_WIDTH-1:0] idRt,
  input  logic [REG_ADDR_WIDTH-1:0] idRd,
  input  logic [DATA_WIDTH-1:0]     idReadData1,
  input  logic [DATA_WIDTH-1:0]     idReadData2,
  input  logic [DATA_WIDTH-1:0]     idImmediate,
  input  logic [EX_CTRL_W-1:0]      idExControl,
  input  logic [MEM_CTRL_W-1:0]     idMemControl,
  input  logic [WB_CTRL_W-1:0]      idWbControl,
  input  logic                      idValid,
  input  logic                      flush,
  input  logic                      extStall,
  output logic [REG_ADDR_WIDTH-1:0] exRs,
  output logic [REG_ADDR_WIDTH-1:0] exRt,
  output logic [REG_ADDR_WIDTH-1:0] exRd,
  output logic [DATA_WIDTH-1:0]     exReadData1,
  output logic [DATA_WIDTH-1:0]     exReadData2,
  output logic [DATA_WIDTH-1:0]     exImmediate,
  output logic [EX_CTRL_W-1:0]      exExControl,
  output logic [MEM_CTRL_W-1:0]     exMemControl,
  output logic [WB_CTRL_W-1:0]      exWbControl,
  output logic                      exValid,
  output logic                      hazardStall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               stallCount,
  output logic [31:0]               flushCount
`endif
);

  logic          loadUse;
  logic          bubble;
  logic          loadUseBubble;
  hazard_state_e state;
  hazard_state_e stateNext;

  load_use_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .exValid  (exValid),
    .exMemRead(exMemControl[MEM_READ_BIT]),
    .exRt     (exRt),
    .idValid  (idValid),
    .idRs     (idRs),
    .idRt     (idRt),
    .loadUse  (loadUse)
  );

  // Gated by reset so the stall drops the moment reset is asserted.
  assign hazardStall   = reset & (loadUse | extStall);
  assign bubble        = ~extStall & (flush | loadUse);
  assign loadUseBubble = ~extStall & ~flush & loadUse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exRs         <= '0;
      exRt         <= '0;
      exRd         <= '0;
      exReadData1  <= '0;
      exReadData2  <= '0;
      exImmediate  <= '0;
      exExControl  <= '0;
      exMemControl <= '0;
      exWbControl  <= '0;
      exValid      <= 1'b0;
    end else if (extStall) begin
      // Hold everything; a pending flush is re-presented once the stall drops.
    end else if (bubble) begin
      exRs         <= '0;
      exRt         <= '0;
      exRd         <= '0;
      exReadData1  <= '0;
      exReadData2  <= '0;
      exImmediate  <= '0;
      exExControl  <= '0;
      exMemControl <= '0;
      exWbControl  <= '0;
      exValid      <= 1'b0;
    end else begin
      exRs         <= idRs;
      exRt         <= idRt;
      exRd         <= idRd;
      exReadData1  <= idReadData1;
      exReadData2  <= idReadData2;
      exImmediate  <= idImmediate;
      exExControl  <= idExControl;
      exMemControl <= idMemControl;
      exWbControl  <= idWbControl;
      exValid      <= idValid;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN:    if (loadUseBubble) stateNext = ST_BUBBLE;
      ST_BUBBLE: stateNext = ST_RUN;
      default:   stateNext = ST_RUN;
    endcase
  end

  a_bubble_one_cycle: assert property (
    @(posedge clock) disable iff (!reset)
    (state == ST_BUBBLE) |=> (state == ST_RUN)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (loadUseBubble) stallCount <= stallCount + 32'd1;
      if (~extStall & flush) flushCount <= flushCount + 32'd1;
    end
  end
`endif

endmodule
